// File: rtl/noc_pkg.sv
// noc_pkg: flit ids, header field offsets, length limit, FSM state type and parity helper for the NoC injector
package noc_pkg;
  localparam logic [2:0] ID_HDR  = 3'b001;
  localparam logic [2:0] ID_BODY = 3'b010;
  localparam logic [2:0] ID_TAIL = 3'b100;
  localparam int ID_LSB  = 29;
  localparam int LEN_LSB = 17;
  localparam int DST_LSB = 13;
  localparam int SRC_LSB = 9;
  localparam int SEQ_LSB = 0;
  localparam int MAX_PAYLOAD = 4094;
  typedef enum logic {IDLE, PAYLOAD} ni_state_t;
  function automatic logic even_par(input logic [30:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/noc_ni_inject.sv
// noc_ni_inject: packetises a core request plus payload stream into HEADER/BODY/TAIL flits for the router local port
//   clk, rst (async, active-low); cur_addr: own address; req_*: packet request (dst, len 1..4094);
//   pl_*: payload words; flit_*: single-register output stage to router; busy; len_err pulse.
//   Optional NOC_NI_PARITY_EN: bit 0 of each flit is even parity over [31:1].
module noc_ni_inject
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int AXIS = 4,
  parameter int LEN_W = 12,
  parameter int SEQ_W = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXIS-1:0]       cur_addr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AXIS-1:0]       req_dst,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [28:0]           pl_data,
  output logic [DATA_WIDTH-1:0] flit_data,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  busy,
  output logic                  len_err
);
  ni_state_t state;
  logic [LEN_W-1:0] remaining;
  logic [SEQ_W-1:0] seq;
  logic slot_free, req_fire, pl_fire, req_bad, hdr_load;
  logic [DATA_WIDTH-1:0] nxt;
  assign slot_free = !flit_valid || flit_ready;
  // rst gating keeps both handshakes low while reset is held
  assign req_ready = rst && state == IDLE && slot_free;
  assign pl_ready = rst && state == PAYLOAD && slot_free;
  assign req_fire = req_valid && req_ready;
  assign pl_fire = pl_valid && pl_ready;
  assign req_bad = req_len == '0 || req_len > LEN_W'(MAX_PAYLOAD);
  assign hdr_load = req_fire && !req_bad;
  assign busy = state != IDLE || flit_valid;
  always_comb begin
    nxt = '0;
    if (state == IDLE) begin
      nxt[ID_LSB +: 3] = ID_HDR;
      nxt[LEN_LSB +: LEN_W] = req_len + 1'b1;
      nxt[DST_LSB +: AXIS] = req_dst;
      nxt[SRC_LSB +: AXIS] = cur_addr;
`ifdef NOC_NI_PARITY_EN
      nxt[SEQ_LSB+1 +: SEQ_W-1] = seq[SEQ_W-2:0];
`else
      nxt[SEQ_LSB +: SEQ_W] = seq;
`endif
    end else begin
      nxt[ID_LSB +: 3] = remaining == LEN_W'(1) ? ID_TAIL : ID_BODY;
`ifdef NOC_NI_PARITY_EN
      nxt[28:1] = pl_data[28:1];
`else
      nxt[28:0] = pl_data;
`endif
    end
`ifdef NOC_NI_PARITY_EN
    nxt[0] = even_par(nxt[31:1]);
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      flit_valid <= 1'b0;
      flit_data <= '0;
      seq <= '0;
      remaining <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= req_fire && req_bad;
      if (hdr_load || pl_fire) begin
        flit_valid <= 1'b1;
        flit_data <= nxt;
      end else if (flit_ready) flit_valid <= 1'b0;
      if (hdr_load) begin
        remaining <= req_len;
        seq <= seq + 1'b1;
        state <= PAYLOAD;
      end
      if (pl_fire) begin
        remaining <= remaining - 1'b1;
        if (remaining == LEN_W'(1)) state <= IDLE;
      end
    end
  end
endmodule
